// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter sharing one backing-memory port between the instruction-fetch and data sides.
// Latency: request pulse in T -> mem_req in T+2 -> x_ready one cycle after mem_ack (T+3 minimum).
// Backpressure: one outstanding request per side; a repeat request while pending is dropped and flags req_ovf.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,

  // instruction-fetch side
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic [31:0] ic_rdata,
  output logic        ic_ready,

  // data side
  input  logic        dc_ren,
  input  logic        dc_wen,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wdata,
  input  logic [3:0]  dc_wmask,
  output logic [31:0] dc_rdata,
  output logic        dc_ready,

  // shared backing-memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,

  // status
  output logic        bus_err,
  output logic        req_ovf,
  output logic [1:0]  grant_out
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_BUSY_IC = 3'b010,
    ST_BUSY_DC = 3'b100
  } state_t;

  state_t      state;

  // per-side pending flags and latched request payloads
  logic        ic_pend;
  logic        dc_pend;
  logic [31:0] ic_addr_q;
  logic [31:0] dc_addr_q;
  logic [31:0] dc_wdata_q;
  logic [3:0]  dc_wmask_q;
  logic        dc_we_q;

  // round-robin history: 1 when the data side won the last completed grant
  logic        last_dc;

  // cycles spent in the current BUSY state
  logic [31:0] busy_cnt;

  logic        dc_new;
  logic        grant_dc;
  logic        grant_ic;
  logic        timeout_hit;
  logic        done;

  // Arbitration and completion decisions derived from registered state.
  always_comb begin
    dc_new      = 1'b0;
    grant_dc    = 1'b0;
    grant_ic    = 1'b0;
    timeout_hit = 1'b0;
    done        = 1'b0;

    dc_new = dc_ren | dc_wen;

    // On a tie the side that did not win last time goes first.
    grant_dc = dc_pend & (~ic_pend | ~last_dc);
    grant_ic = ic_pend & ~grant_dc;

    // A zero limit disables the watchdog entirely.
    if (TIMEOUT_CYCLES != 0) begin
      timeout_hit = ((busy_cnt + 32'd1) == TIMEOUT_CYCLES);
    end

    // A real acknowledge always wins over a coincident timeout.
    done = mem_ack | timeout_hit;
  end

  // Ownership is a direct decode of the FSM state.
  assign grant_out = {state == ST_BUSY_DC, state == ST_BUSY_IC};

  // Request capture, arbitration FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ic_pend    <= 1'b0;
      dc_pend    <= 1'b0;
      ic_addr_q  <= 32'd0;
      dc_addr_q  <= 32'd0;
      dc_wdata_q <= 32'd0;
      dc_wmask_q <= 4'd0;
      dc_we_q    <= 1'b0;
      last_dc    <= 1'b0;
      busy_cnt   <= 32'd0;
      req_ovf    <= 1'b0;
      ic_rdata   <= 32'd0;
      dc_rdata   <= 32'd0;
      ic_ready   <= 1'b0;
      dc_ready   <= 1'b0;
      bus_err    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wmask  <= 4'd0;
    end else begin
      // completion strobes are single-cycle
      ic_ready <= 1'b0;
      dc_ready <= 1'b0;
      bus_err  <= 1'b0;

      // Instruction side: capture a new fetch, or flag it if one is still outstanding.
      if (ic_req) begin
        if (ic_pend) begin
          req_ovf <= 1'b1;
        end else begin
          ic_pend   <= 1'b1;
          ic_addr_q <= ic_addr;
        end
      end

      // Data side: read and write together is resolved as a write but still flagged.
      if (dc_new) begin
        if (dc_ren && dc_wen) begin
          req_ovf <= 1'b1;
        end
        if (dc_pend) begin
          req_ovf <= 1'b1;
        end else begin
          dc_pend    <= 1'b1;
          dc_addr_q  <= dc_addr;
          dc_wdata_q <= dc_wdata;
          dc_wmask_q <= dc_wmask;
          dc_we_q    <= dc_wen;
        end
      end

      case (state)
        ST_IDLE: begin
          // Stray acknowledges in IDLE are ignored; only pending flags matter here.
          if (grant_dc) begin
            state     <= ST_BUSY_DC;
            busy_cnt  <= 32'd0;
            mem_req   <= 1'b1;
            mem_we    <= dc_we_q;
            mem_addr  <= dc_addr_q;
            mem_wdata <= dc_wdata_q;
            mem_wmask <= dc_wmask_q;
          end else if (grant_ic) begin
            state     <= ST_BUSY_IC;
            busy_cnt  <= 32'd0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= ic_addr_q;
            mem_wdata <= 32'd0;
            mem_wmask <= 4'd0;
          end
        end

        ST_BUSY_IC: begin
          if (done) begin
            state     <= ST_IDLE;
            ic_pend   <= 1'b0;
            last_dc   <= 1'b0;
            ic_rdata  <= mem_ack ? mem_rdata : 32'd0;
            ic_ready  <= 1'b1;
            bus_err   <= ~mem_ack;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wmask <= 4'd0;
          end else begin
            busy_cnt <= busy_cnt + 32'd1;
          end
        end

        ST_BUSY_DC: begin
          if (done) begin
            state     <= ST_IDLE;
            dc_pend   <= 1'b0;
            last_dc   <= 1'b1;
            // writes return nothing, so the last load value stays visible
            if (!dc_we_q) begin
              dc_rdata <= mem_ack ? mem_rdata : 32'd0;
            end
            dc_ready  <= 1'b1;
            bus_err   <= ~mem_ack;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wmask <= 4'd0;
          end else begin
            busy_cnt <= busy_cnt + 32'd1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= 32'd0;
          mem_wdata <= 32'd0;
          mem_wmask <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter with a scoreboard of expected completions.
// Latency: checks the T -> T+2 -> T+3 request/grant/ready timing and the 4-cycle watchdog.
// Backpressure: exercises overflow on repeat requests and capture of the idle side during BUSY.
module tb_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_ready;
  logic        dc_ren;
  logic        dc_wen;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic [3:0]  dc_wmask;
  logic [31:0] dc_rdata;
  logic        dc_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;
  logic        req_ovf;
  logic [1:0]  grant_out;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
    .dc_ren(dc_ren), .dc_wen(dc_wen), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wmask(dc_wmask), .dc_rdata(dc_rdata), .dc_ready(dc_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err), .req_ovf(req_ovf), .grant_out(grant_out)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        ic_q[$];
  exp_t        dc_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] dc_last;
  logic [31:0] ic_last;
  bit          ack_en;
  int          ack_delay;
  int          wait_cnt;

  // memory contents model: fixed word for the fetch vector, address-derived otherwise
  function automatic logic [31:0] exp_data(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], 16'hC0DE} ^ 32'h5A5A_0000;
  endfunction

  function automatic exp_t mk(input logic [31:0] d, input logic e);
    exp_t r;
    r.data = d;
    r.err  = e;
    return r;
  endfunction

  // memory responder: acks after ack_delay extra cycles of mem_req while enabled
  always begin
    @(posedge clk); #1;
    if (ack_en) begin
      if (mem_req === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = exp_data(mem_addr);
          wait_cnt  = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'hBAD0_0000;
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // scoreboard: every ready pulse must match the oldest expected completion of that side
  always begin : monitor
    exp_t e;
    @(posedge clk); #3;
    if (ic_ready === 1'b1) begin
      n_vec++;
      if (ic_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_ic_unexpected: ic_ready pulsed, required no pulse");
      end else begin
        e = ic_q.pop_front();
        if (ic_rdata !== e.data || bus_err !== e.err) begin
          n_err++;
          $display("FAIL sb_ic: got rdata=%h err=%b, required rdata=%h err=%b", ic_rdata, bus_err, e.data, e.err);
        end
      end
    end
    if (dc_ready === 1'b1) begin
      n_vec++;
      if (dc_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_dc_unexpected: dc_ready pulsed, required no pulse");
      end else begin
        e = dc_q.pop_front();
        if (dc_rdata !== e.data || bus_err !== e.err) begin
          n_err++;
          $display("FAIL sb_dc: got rdata=%h err=%b, required rdata=%h err=%b", dc_rdata, bus_err, e.data, e.err);
        end
      end
    end
    if (bus_err === 1'b1 && ic_ready !== 1'b1 && dc_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_lone_bus_err: bus_err=1 without ready, required together");
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    ic_req = 1'b0; ic_addr = 32'd0;
    dc_ren = 1'b0; dc_wen = 1'b0; dc_addr = 32'd0; dc_wdata = 32'd0; dc_wmask = 4'd0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    idle_inputs();
    ic_q.delete();
    dc_q.delete();
    dc_last = 32'd0;
    ic_last = 32'd0;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(3);
    n_vec++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask} !== 70'd0) begin
      n_err++; $display("FAIL reset_mem: got req=%b we=%b addr=%h, required all zero", mem_req, mem_we, mem_addr);
    end
    n_vec++;
    if ({ic_ready, dc_ready, ic_rdata, dc_rdata} !== 66'd0) begin
      n_err++; $display("FAIL reset_rd: got ic=%b/%h dc=%b/%h, required zero", ic_ready, ic_rdata, dc_ready, dc_rdata);
    end
    n_vec++;
    if ({bus_err, req_ovf, grant_out} !== 4'd0) begin
      n_err++; $display("FAIL reset_flags: got err=%b ovf=%b grant=%b, required 0", bus_err, req_ovf, grant_out);
    end
    tick();
    n_vec++;
    if (grant_out !== 2'b00 || mem_req !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: got grant=%b req=%b, required 00/0", grant_out, mem_req);
    end
  endtask

  task automatic test_single_fetch;
    ack_en = 1'b1; ack_delay = 0;
    ic_req = 1'b1; ic_addr = 32'h100;
    ic_q.push_back(mk(32'hDEADBEEF, 1'b0));
    tick();                                  // T+1
    ic_req = 1'b0; ic_addr = 32'hFFFF_FFFF;
    n_vec++;
    if (mem_req !== 1'b0) begin
      n_err++; $display("FAIL fetch_t1: got mem_req=%b, required 0", mem_req);
    end
    tick();                                  // T+2
    n_vec++;
    if ({mem_req, mem_we, mem_wmask, mem_addr, grant_out} !== {1'b1, 1'b0, 4'h0, 32'h100, 2'b01}) begin
      n_err++; $display("FAIL fetch_t2: got req=%b we=%b mask=%h addr=%h grant=%b, required 1 0 0 100 01",
                        mem_req, mem_we, mem_wmask, mem_addr, grant_out);
    end
    tick();                                  // T+3
    n_vec++;
    if (ic_ready !== 1'b1 || ic_rdata !== 32'hDEADBEEF || mem_req !== 1'b0) begin
      n_err++; $display("FAIL fetch_t3: got ready=%b rdata=%h req=%b, required 1 deadbeef 0", ic_ready, ic_rdata, mem_req);
    end
    tick();                                  // T+4
    n_vec++;
    if (ic_ready !== 1'b0 || ic_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL fetch_hold: got ready=%b rdata=%h, required 0 deadbeef", ic_ready, ic_rdata);
    end
    ic_last = 32'hDEADBEEF;
  endtask

  task automatic test_round_robin;
    do_reset(2);
    ack_en = 1'b1; ack_delay = 0;
    ic_req = 1'b1; ic_addr = 32'h200;
    dc_ren = 1'b1; dc_addr = 32'h300;
    ic_q.push_back(mk(exp_data(32'h200), 1'b0));
    dc_q.push_back(mk(exp_data(32'h300), 1'b0));
    dc_last = exp_data(32'h300);
    tick(); idle_inputs();                   // T+1
    tick();                                  // T+2
    n_vec++;
    if (grant_out !== 2'b10 || mem_addr !== 32'h300) begin
      n_err++; $display("FAIL tie1_first: got grant=%b addr=%h, required 10 300", grant_out, mem_addr);
    end
    tick();                                  // T+3
    n_vec++;
    if (dc_ready !== 1'b1 || grant_out !== 2'b00) begin
      n_err++; $display("FAIL tie1_dc_done: got ready=%b grant=%b, required 1 00", dc_ready, grant_out);
    end
    tick();                                  // T+4
    n_vec++;
    if (grant_out !== 2'b01 || mem_addr !== 32'h200) begin
      n_err++; $display("FAIL tie1_second: got grant=%b addr=%h, required 01 200", grant_out, mem_addr);
    end
    tick();                                  // T+5
    ic_last = exp_data(32'h200);
    // a lone data read makes DC the last winner, so the next tie goes to IC
    dc_ren = 1'b1; dc_addr = 32'h304;
    dc_q.push_back(mk(exp_data(32'h304), 1'b0));
    dc_last = exp_data(32'h304);
    tick(); idle_inputs();
    tick(); tick();
    ic_req = 1'b1; ic_addr = 32'h208;
    dc_ren = 1'b1; dc_addr = 32'h30C;
    ic_q.push_back(mk(exp_data(32'h208), 1'b0));
    dc_q.push_back(mk(exp_data(32'h30C), 1'b0));
    dc_last = exp_data(32'h30C);
    ic_last = exp_data(32'h208);
    tick(); idle_inputs();
    tick();
    n_vec++;
    if (grant_out !== 2'b01 || mem_addr !== 32'h208) begin
      n_err++; $display("FAIL tie2_first: got grant=%b addr=%h, required 01 208", grant_out, mem_addr);
    end
    repeat (4) tick();
  endtask

  task automatic test_dc_write;
    ack_en = 1'b1; ack_delay = 2;
    dc_wen = 1'b1; dc_addr = 32'h20; dc_wdata = 32'h12345678; dc_wmask = 4'b0011;
    dc_q.push_back(mk(dc_last, 1'b0));
    tick();
    dc_wen = 1'b0; dc_addr = 32'hFFFF_0000; dc_wdata = 32'h0BAD_0BAD; dc_wmask = 4'b1100;
    tick();                                  // T+2
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011}) begin
        n_err++; $display("FAIL wr_hold%0d: got req=%b we=%b addr=%h wdata=%h mask=%b, required 1 1 20 12345678 0011",
                          i, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask);
      end
      tick();
    end                                      // T+5
    n_vec++;
    if (dc_ready !== 1'b1 || dc_rdata !== dc_last || mem_req !== 1'b0) begin
      n_err++; $display("FAIL wr_done: got ready=%b rdata=%h req=%b, required 1 %h 0", dc_ready, dc_rdata, mem_req, dc_last);
    end
    tick();
  endtask

  task automatic test_timeout;
    ack_en = 1'b0; mem_ack = 1'b0;
    dc_ren = 1'b1; dc_addr = 32'h40;
    dc_q.push_back(mk(32'd0, 1'b1));
    dc_last = 32'd0;
    tick(); idle_inputs();
    tick();                                  // T+2, first BUSY cycle
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (mem_req !== 1'b1 || grant_out !== 2'b10) begin
        n_err++; $display("FAIL to_busy%0d: got req=%b grant=%b, required 1 10", i, mem_req, grant_out);
      end
      tick();
    end                                      // T+6
    n_vec++;
    if ({dc_ready, bus_err, dc_rdata, grant_out, mem_req} !== {1'b1, 1'b1, 32'd0, 2'b00, 1'b0}) begin
      n_err++; $display("FAIL to_done: got ready=%b err=%b rdata=%h grant=%b req=%b, required 1 1 0 00 0",
                        dc_ready, bus_err, dc_rdata, grant_out, mem_req);
    end
    tick();
    n_vec++;
    if (bus_err !== 1'b0) begin
      n_err++; $display("FAIL to_pulse: got bus_err=%b, required 0", bus_err);
    end
  endtask

  task automatic test_ack_idle;
    ack_en = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick(); tick();
    mem_ack = 1'b0;
    n_vec++;
    if ({mem_req, grant_out} !== 3'b000 || ic_rdata !== ic_last || dc_rdata !== dc_last) begin
      n_err++; $display("FAIL ack_idle: got req=%b grant=%b ic=%h dc=%h, required 0 00 %h %h",
                        mem_req, grant_out, ic_rdata, dc_rdata, ic_last, dc_last);
    end
    tick();
  endtask

  task automatic test_overflow;
    do_reset(2);
    ack_en = 1'b1; ack_delay = 3;
    ic_req = 1'b1; ic_addr = 32'h500;
    ic_q.push_back(mk(exp_data(32'h500), 1'b0));
    tick();
    ic_addr = 32'h600;                       // repeat while still pending
    tick(); idle_inputs();
    n_vec++;
    if (req_ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_ic: got req_ovf=%b, required 1", req_ovf);
    end
    repeat (8) tick();
    n_vec++;
    if (ic_rdata !== exp_data(32'h500) || req_ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_ic_data: got rdata=%h ovf=%b, required %h 1", ic_rdata, req_ovf, exp_data(32'h500));
    end
    // read and write together: resolved as a write, flagged as overflow
    do_reset(2);
    n_vec++;
    if (req_ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear: got req_ovf=%b, required 0", req_ovf);
    end
    dc_ren = 1'b1; dc_wen = 1'b1; dc_addr = 32'h80; dc_wdata = 32'hA5A5A5A5; dc_wmask = 4'hF;
    dc_q.push_back(mk(32'd0, 1'b0));
    tick(); idle_inputs();
    n_vec++;
    if (req_ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_rw: got req_ovf=%b, required 1", req_ovf);
    end
    tick();
    n_vec++;
    if ({mem_req, mem_we, mem_wdata} !== {1'b1, 1'b1, 32'hA5A5A5A5}) begin
      n_err++; $display("FAIL rw_is_write: got req=%b we=%b wdata=%h, required 1 1 a5a5a5a5", mem_req, mem_we, mem_wdata);
    end
    repeat (6) tick();
  endtask

  task automatic test_capture_busy;
    ack_en = 1'b1; ack_delay = 2;
    ic_req = 1'b1; ic_addr = 32'h700;
    ic_q.push_back(mk(exp_data(32'h700), 1'b0));
    ic_last = exp_data(32'h700);
    tick(); idle_inputs();                   // T+1
    tick();                                  // T+2, BUSY_IC
    dc_ren = 1'b1; dc_addr = 32'h704;
    dc_q.push_back(mk(exp_data(32'h704), 1'b0));
    dc_last = exp_data(32'h704);
    tick(); idle_inputs();                   // T+3
    tick();                                  // T+4
    tick();                                  // T+5
    n_vec++;
    if (grant_out !== 2'b00) begin
      n_err++; $display("FAIL cap_idle: got grant=%b, required 00", grant_out);
    end
    tick();                                  // T+6
    n_vec++;
    if (grant_out !== 2'b10 || mem_addr !== 32'h704) begin
      n_err++; $display("FAIL cap_grant: got grant=%b addr=%h, required 10 704", grant_out, mem_addr);
    end
    repeat (5) tick();
  endtask

  task automatic test_reset_mid;
    ack_en = 1'b0; mem_ack = 1'b0;
    dc_ren = 1'b1; dc_addr = 32'h900;
    tick(); idle_inputs();
    tick();                                  // T+2, BUSY_DC
    n_vec++;
    if (grant_out !== 2'b10) begin
      n_err++; $display("FAIL rmid_busy: got grant=%b, required 10", grant_out);
    end
    ic_req = 1'b1; ic_addr = 32'h904;        // pending on the other side too
    tick();
    ic_req = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    dc_last = 32'd0;
    ic_last = 32'd0;
    n_vec++;
    if ({mem_req, grant_out, dc_ready, dc_rdata} !== 36'd0) begin
      n_err++; $display("FAIL rmid_drop: got req=%b grant=%b ready=%b rdata=%h, required all 0",
                        mem_req, grant_out, dc_ready, dc_rdata);
    end
    ack_en = 1'b1; ack_delay = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (mem_req !== 1'b0 || dc_ready !== 1'b0 || ic_ready !== 1'b0) begin
        n_err++; $display("FAIL rmid_quiet%0d: got req=%b dcr=%b icr=%b, required 0 0 0", i, mem_req, dc_ready, ic_ready);
      end
    end
  endtask

  initial begin
    ack_en = 1'b0; ack_delay = 0; wait_cnt = 0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    reset = 1'b0;
    idle_inputs();
    dc_last = 32'd0;
    ic_last = 32'd0;

    test_reset();
    test_single_fetch();
    test_round_robin();
    test_dc_write();
    test_timeout();
    test_ack_idle();
    test_overflow();
    test_capture_busy();
    test_reset_mid();

    repeat (3) tick();
    n_vec++;
    if (ic_q.size() != 0 || dc_q.size() != 0) begin
      n_err++; $display("FAIL sb_drain: got %0d ic and %0d dc completions missing, required 0", ic_q.size(), dc_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: BUSY-cycle limit before forced completion; 0 disables the timeout.
REQ-002 SHALL have ports: clk  in  1  clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have ic_req  in  1, ic_addr  in  32: instruction fetch request pulse and its address.
REQ-005 SHALL have ic_rdata  out  32, ic_ready  out  1: fetch data and one-cycle completion pulse.
REQ-006 SHALL have dc_ren  in  1, dc_wen  in  1, dc_addr  in  32, dc_wdata  in  32, dc_wmask  in  4: data-side read/write request pulse, address, write data, byte mask.
REQ-007 SHALL have dc_rdata  out  32, dc_ready  out  1: load data and one-cycle completion pulse.
REQ-008 SHALL have mem_req  out  1, mem_we  out  1, mem_addr  out  32, mem_wdata  out  32, mem_wmask  out  4: single shared backing-memory port.
REQ-009 SHALL have mem_rdata  in  32, mem_ack  in  1: memory read data and acknowledge.
REQ-010 SHALL have bus_err  out  1 (timeout pulse), req_ovf  out  1 (sticky overflow flag), grant_out  out  2 (bit0=IC owns, bit1=DC owns).

Function
REQ-011 Request capture: a cycle with ic_req=1 (or dc_ren|dc_wen=1) SHALL set that port's pending bit and latch its address/data/mask/write-type at that clock edge.
REQ-012 A request arriving while the same port is already pending SHALL be ignored and SHALL set req_ovf (sticky until reset).
REQ-013 dc_ren and dc_wen both high SHALL be treated as a write and SHALL set req_ovf.
REQ-014 FSM states: IDLE, BUSY_IC, BUSY_DC; one-hot encoded.
REQ-015 IDLE: only IC pending -> BUSY_IC; only DC pending -> BUSY_DC; neither pending -> stay in IDLE.
REQ-016 IDLE with both pending: grant the port NOT granted last (round-robin); last-grant register resets to IC, so the first tie goes to DC.
REQ-017 In BUSY_x, mem_req SHALL be 1 with mem_addr/mem_we/mem_wdata/mem_wmask driven from x's latched values, held stable until completion; mem_we=0 and mem_wmask=0 for IC.
REQ-018 In IDLE, mem_req=0 and all other mem_* outputs SHALL be 0.
REQ-019 Completion: mem_ack=1 in BUSY_x SHALL transition to IDLE, clear x's pending bit, update last-grant to x, and register x_rdata<=mem_rdata (DC writes leave dc_rdata unchanged).
REQ-020 x_ready SHALL pulse exactly one cycle, in the cycle after completion; x_rdata SHALL hold until x's next completion.
REQ-021 Minimum latency: request pulse in cycle T -> mem_req first high in T+2 -> with mem_ack in T+2, x_ready=1 in T+3.
REQ-022 mem_ack while in IDLE SHALL be ignored.
REQ-023 Timeout: the cycle counter clears on entering BUSY and increments each BUSY cycle; reaching TIMEOUT_CYCLES without mem_ack SHALL complete as in REQ-019, but with x_rdata<=0.
REQ-024 A timeout completion SHALL pulse bus_err together with x_ready.
REQ-025 A new request on the port not being served SHALL be captured during BUSY and granted on the next IDLE.
REQ-026 grant_out SHALL equal {state==BUSY_DC, state==BUSY_IC}.

Reset
REQ-027 With reset=0 at a clock edge: state<=IDLE, pending bits<=0, last-grant<=IC, counter<=0, req_ovf<=0.
REQ-028 The same reset edge SHALL zero ic_rdata, dc_rdata, ic_ready, dc_ready, bus_err and all mem_* outputs.
REQ-029 Reset mid-transaction SHALL drop mem_req in the following cycle and SHALL NOT produce a ready pulse for the aborted request.

Verification
REQ-030 Single IC fetch: ic_req at T, addr 0x100; mem_ack at T+2 with rdata 0xDEADBEEF -> ic_ready=1 at T+3, ic_rdata=0xDEADBEEF.
REQ-031 Simultaneous ic_req and dc_ren after reset -> DC served first (grant_out=2'b10), then IC (2'b01); each ready pulses once.
REQ-032 DC write, addr 0x20, wdata 0x12345678, wmask 4'b0011 -> mem_we=1 with those values held until ack; dc_rdata unchanged.
REQ-033 TIMEOUT_CYCLES=4, mem_ack never asserted -> after 4 BUSY cycles: bus_err=1 with dc_ready=1, dc_rdata=0; state back to IDLE.
REQ-034 Second ic_req while IC still pending -> req_ovf=1, exactly one ic_ready pulse.
REQ-035 reset=0 asserted during BUSY_DC -> mem_req=0 next cycle, no dc_ready pulse, all pending bits clear.
